frame_capture_writer: RTL and testbench

- Writer side of the 640x480 RGB444 frame buffer: turns a synchronized camera byte stream into frame-buffer write transactions.
- Drives the port-A inputs of `frame_buffer`: `memory_write_addr`, `memory_write_data`, `memory_write_enable`.
- The VGA playback path reads the same buffer through port B.
- Captures one whole frame per request, or every frame in continuous mode; reports completion, frame count and framing errors.

---
 rtl/frame_capture_writer.sv | 141 ++++++++++++++
 tb/tb_frame_capture_writer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_writer.sv
// Camera byte stream to frame-buffer port-A writer: assembles RGB444 pixels from
// byte pairs, tracks line/column position and reports per-frame framing errors.
module frame_capture_writer #(
  parameter int unsigned H_PIXELS   = 640,
  parameter int unsigned V_LINES    = 480,
  parameter int unsigned ADDR_WIDTH = 19
) (
  input  logic                  clk_25mhz,
  input  logic                  reset,
  input  logic [7:0]            cam_byte,
  input  logic                  cam_byte_valid,
  input  logic                  cam_href,
  input  logic                  cam_vsync,
  input  logic                  capture_start,
  input  logic                  continuous,
  output logic [ADDR_WIDTH-1:0] memory_write_addr,
  output logic [11:0]           memory_write_data,
  output logic                  memory_write_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_error,
  output logic [7:0]            frame_count
);

  localparam int unsigned XW = $clog2(H_PIXELS + 1);
  localparam int unsigned LW = $clog2(V_LINES + 2);
  localparam logic [XW-1:0]         H_END  = XW'(H_PIXELS);
  localparam logic [LW-1:0]         V_END  = LW'(V_LINES);
  localparam logic [ADDR_WIDTH-1:0] H_STEP = ADDR_WIDTH'(H_PIXELS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_CAPTURE, S_DONE} state_t;

  state_t                  state, state_next;
  logic                    vsync_d, href_d;
  logic                    phase;
  logic [3:0]              r_nib;
  logic [XW-1:0]           x;
  logic [LW-1:0]           line, line_after;
  logic [ADDR_WIDTH-1:0]   line_base;
  logic                    err, err_next;
  logic                    vsync_fall, vsync_rise, href_fall;
  logic                    byte_en, pix_byte, pix_ok, pix_excess;
  logic                    line_close, line_err;

  assign vsync_fall = ~cam_vsync & vsync_d;
  assign vsync_rise = cam_vsync & ~vsync_d;
  assign href_fall  = ~cam_href & href_d;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk_25mhz) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:     if (capture_start || continuous) state_next = S_WAIT_SOF;
      S_WAIT_SOF: if (vsync_fall) state_next = S_CAPTURE;
      S_CAPTURE:  if (vsync_rise) state_next = S_DONE;
      S_DONE:     state_next = continuous ? S_WAIT_SOF : S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // The line close is folded into line_after/err_next so a vsync_rise in the
  // same cycle judges the frame on the already-closed line count.
  always_comb begin
    byte_en    = cam_byte_valid & cam_href;
    pix_byte   = byte_en & phase;
    pix_ok     = pix_byte & (x < H_END) & (line < V_END);
    pix_excess = pix_byte & ~pix_ok;
    line_close = href_fall & (x != '0);
    line_err   = line_close & ((x != H_END) | phase);
    line_after = line;
    if (line_close && (line <= V_END)) line_after = line + 1'b1;
    err_next   = err | pix_excess | line_err | (vsync_rise & (line_after != V_END));
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      vsync_d             <= 1'b0;
      href_d              <= 1'b0;
      phase               <= 1'b0;
      r_nib               <= '0;
      x                   <= '0;
      line                <= '0;
      line_base           <= '0;
      err                 <= 1'b0;
      memory_write_addr   <= '0;
      memory_write_data   <= '0;
      memory_write_enable <= 1'b0;
      frame_error         <= 1'b0;
      frame_count         <= '0;
    end else begin
      vsync_d             <= cam_vsync;
      href_d              <= cam_href;
      memory_write_enable <= 1'b0;
      unique case (state)
        S_WAIT_SOF: begin
          x         <= '0;
          line      <= '0;
          line_base <= '0;
          phase     <= 1'b0;
          err       <= 1'b0;
        end
        S_CAPTURE: begin
          if (byte_en) begin
            if (!phase) begin
              r_nib <= cam_byte[3:0];
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (pix_ok) begin
                memory_write_enable <= 1'b1;
                memory_write_data   <= {r_nib, cam_byte};
                memory_write_addr   <= line_base + ADDR_WIDTH'(x);
              end
              if (x < H_END) x <= x + 1'b1;
            end
          end
          if (line_close) begin
            x     <= '0;
            phase <= 1'b0;
            line  <= line_after;
            if (line < V_END) line_base <= line_base + H_STEP;
          end
          err <= err_next;
          if (vsync_rise) begin
            frame_count <= frame_count + 1'b1;
            frame_error <= err_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_capture_writer.sv
// Directed bench for frame_capture_writer on a reduced 8x6 frame; a frame-level
// model predicts every write and every done pulse.
module tb_frame_capture_writer;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int AW = 19;

  logic          clk_25mhz = 1'b0;
  logic          reset;
  logic [7:0]    cam_byte;
  logic          cam_byte_valid, cam_href, cam_vsync;
  logic          capture_start, continuous;
  logic [AW-1:0] memory_write_addr;
  logic [11:0]   memory_write_data;
  logic          memory_write_enable, busy, done, frame_error;
  logic [7:0]    frame_count;

  always #20 clk_25mhz = ~clk_25mhz;

  frame_capture_writer #(.H_PIXELS(H), .V_LINES(V), .ADDR_WIDTH(AW)) dut (
    .clk_25mhz(clk_25mhz), .reset(reset), .cam_byte(cam_byte),
    .cam_byte_valid(cam_byte_valid), .cam_href(cam_href), .cam_vsync(cam_vsync),
    .capture_start(capture_start), .continuous(continuous),
    .memory_write_addr(memory_write_addr), .memory_write_data(memory_write_data),
    .memory_write_enable(memory_write_enable), .busy(busy), .done(done),
    .frame_error(frame_error), .frame_count(frame_count)
  );

  int checks = 0, errors = 0;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { bit err; int cnt; } dn_t;
  wr_t exp_wr[$];
  dn_t exp_dn[$];

  // model: armed = next frame start is captured; capturing = current frame is
  bit m_armed = 0, m_capturing = 0, m_err = 0;
  int m_count = 0;

  int  lb[0:15];
  int  mid_req_line = -1, clr_cont_line = -1, reset_at = -1;
  bit  seen[H*V];
  int  frame_writes = 0, done_seen = 0, first_addr = -1, first_data = -1, last_addr = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_25mhz) begin
    if (memory_write_enable) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0d expected no write", memory_write_addr);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("write_addr", 32'(memory_write_addr), 32'(w.addr));
        chk("write_data", 32'(memory_write_data), 32'(w.data));
      end
      if (memory_write_addr < AW'(H*V)) seen[memory_write_addr] = 1'b1;
      if (frame_writes == 0) begin
        first_addr = int'(memory_write_addr);
        first_data = int'(memory_write_data);
      end
      last_addr = int'(memory_write_addr);
      frame_writes++;
    end
    if (done) begin
      done_seen++;
      if (exp_dn.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected 0");
      end else begin
        dn_t d;
        d = exp_dn.pop_front();
        chk("frame_error", 32'(frame_error), 32'(d.err));
        chk("frame_count", 32'(frame_count), 32'(d.cnt));
      end
    end
  end

  task automatic tick;
    @(posedge clk_25mhz);
    #1;
  endtask

  function automatic logic [7:0] bval(input int f, input int l, input int k);
    if (l == 0 && k == 0) return 8'h0A;
    if (l == 0 && k == 1) return 8'hBC;
    return 8'((f * 37 + l * 13 + k * 7 + 1) & 255);
  endfunction

  task automatic reset_stats;
    for (int i = 0; i < H * V; i++) seen[i] = 1'b0;
    frame_writes = 0; first_addr = -1; first_data = -1; last_addr = -1;
  endtask

  task automatic pulse_start;
    if (!m_armed && !m_capturing) m_armed = 1;
    capture_start = 1; tick; capture_start = 0;
  endtask

  // A vsync rise ends whichever frame was being captured.
  task automatic close_prev;
    if (m_capturing) begin
      m_count = (m_count + 1) % 256;
      exp_dn.push_back('{err: m_err, cnt: m_count});
      m_capturing = 0;
      m_armed = continuous;
    end
  endtask

  task automatic send_frame(input int nlines, input int f);
    bit cap, err;
    int nlc, pixcnt;
    logic [7:0] prevb;
    close_prev();
    cam_vsync = 1; tick; tick; tick;
    cam_vsync = 0;
    cap = m_armed; m_capturing = cap; m_armed = 0;
    tick; tick;
    err = 0; nlc = 0; pixcnt = 0; prevb = '0;
    for (int l = 0; l < nlines; l++) begin
      if (l == mid_req_line) pulse_start();
      if (l == clr_cont_line) continuous = 0;
      cam_href = 1;
      for (int k = 0; k < lb[l]; k++) begin
        cam_byte = bval(f, l, k);
        cam_byte_valid = 1;
        if (cap && (k % 2 == 1) && (k / 2 < H) && nlc < V)
          exp_wr.push_back('{addr: nlc * H + k / 2, data: int'({prevb[3:0], cam_byte})});
        prevb = cam_byte;
        tick;
        if (k % 2 == 1) pixcnt++;
        if (cap && k % 2 == 1 && pixcnt == reset_at) begin
          cam_byte_valid = 0;
          reset = 1; tick; reset = 0;
          chk("rst_mid_we", 32'(memory_write_enable), 0);
          chk("rst_mid_busy", 32'(busy), 0);
          chk("rst_mid_count", 32'(frame_count), 0);
          cap = 0; m_capturing = 0; m_armed = 0; m_count = 0;
        end
        if (k % 5 == 4) begin
          cam_byte_valid = 0; cam_byte = 8'h5A; tick;
        end
      end
      cam_href = 0; cam_byte_valid = 0;
      if (lb[l] / 2 > 0) begin
        if (lb[l] / 2 != H || lb[l] % 2 == 1) err = 1;
        nlc++;
      end
      tick; tick; tick;
    end
    if (nlc != V) err = 1;
    m_err = err;
  endtask

  task automatic end_frame;
    close_prev();
    cam_vsync = 1; tick; tick; tick;
    cam_vsync = 0; tick; tick; tick;
  endtask

  task automatic default_lines;
    for (int i = 0; i < 16; i++) lb[i] = 2 * H;
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset = 1; cam_byte = '0; cam_byte_valid = 0; cam_href = 0; cam_vsync = 0;
    capture_start = 0; continuous = 0;
    default_lines();
    tick; tick; tick;
    chk("reset_we", 32'(memory_write_enable), 0);
    chk("reset_addr", 32'(memory_write_addr), 0);
    chk("reset_data", 32'(memory_write_data), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_ferr", 32'(frame_error), 0);
    chk("reset_fcount", 32'(frame_count), 0);
    reset = 0; tick;

    // nominal frame, with a stray request during capture
    reset_stats();
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    mid_req_line = 3;
    send_frame(V, 0);
    end_frame();
    mid_req_line = -1;
    chk("nom_writes", 32'(frame_writes), 48);
    chk("nom_first_addr", 32'(first_addr), 0);
    chk("nom_first_data", 32'(first_data), 32'h0ABC);
    chk("nom_last_addr", 32'(last_addr), 47);
    chk("nom_ferr", 32'(frame_error), 0);
    chk("nom_fcount", 32'(frame_count), 1);
    chk("nom_busy_after", 32'(busy), 0);

    // request mid-frame: that frame is skipped, the next one captured from 0
    reset_stats();
    mid_req_line = 2;
    send_frame(V, 1);
    mid_req_line = -1;
    chk("mid_no_writes", 32'(frame_writes), 0);
    send_frame(V, 2);
    end_frame();
    chk("mid_first_addr", 32'(first_addr), 0);
    chk("mid_writes", 32'(frame_writes), 48);
    chk("mid_fcount", 32'(frame_count), 2);

    // short line 1: 7 pixels at 8..14, line 2 starts at 16
    reset_stats();
    lb[1] = 2 * H - 2;
    pulse_start();
    send_frame(V, 3);
    end_frame();
    default_lines();
    chk("short_addr14", 32'(seen[14]), 1);
    chk("short_addr15", 32'(seen[15]), 0);
    chk("short_addr16", 32'(seen[16]), 1);
    chk("short_writes", 32'(frame_writes), 47);
    chk("short_ferr", 32'(frame_error), 1);

    // long odd line 0 and two extra lines
    reset_stats();
    lb[0] = 2 * H + 3;
    pulse_start();
    send_frame(V + 2, 4);
    end_frame();
    default_lines();
    chk("long_writes", 32'(frame_writes), 48);
    chk("long_last_addr", 32'(last_addr), 47);
    chk("long_ferr", 32'(frame_error), 1);
    chk("long_fcount", 32'(frame_count), 4);

    // continuous mode, dropped during frame 3
    reset_stats();
    d0 = done_seen;
    continuous = 1;
    m_armed = 1;
    tick; tick;
    send_frame(V, 5);
    send_frame(V, 6);
    clr_cont_line = 2;
    send_frame(V, 7);
    clr_cont_line = -1;
    send_frame(V, 8);
    end_frame();
    chk("cont_dones", 32'(done_seen - d0), 3);
    chk("cont_writes", 32'(frame_writes), 144);
    chk("cont_fcount", 32'(frame_count), 7);
    chk("cont_busy_after", 32'(busy), 0);

    // reset mid-capture, then a frame with no request, then a fresh capture
    reset_at = 20;
    pulse_start();
    send_frame(V, 9);
    reset_at = -1;
    reset_stats();
    send_frame(V, 10);
    end_frame();
    chk("rst_no_writes", 32'(frame_writes), 0);
    chk("rst_idle_count", 32'(frame_count), 0);
    reset_stats();
    pulse_start();
    send_frame(V, 11);
    end_frame();
    chk("rst_recap_writes", 32'(frame_writes), 48);
    chk("rst_recap_fcount", 32'(frame_count), 1);

    tick; tick;
    chk("pending_writes", 32'(exp_wr.size()), 0);
    chk("pending_dones", 32'(exp_dn.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
